sliced_subtractor: RTL

- Multicycle 32-bit subtractor that computes sub_result = A - B one slice per cycle and holds the carry between slices in a register.
- Sits directly upstream of the ALU's not-equal/zero-detect stage. The downstream stage ORs all bits of sub_result, so this block must present a stable 32-bit difference while out_valid is high.
- Also produces the signed less-than and overflow flags from the same subtraction.
- Uses a valid/ready handshake on both input and output so the processor can stall on either side.

---
 rtl/sliced_subtractor.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sliced_subtractor.sv
// -----------------------------------------------------------------------------
// sliced_subtractor
//   Multicycle subtractor: sub_result = A - B, computed SLICE_W bits per cycle
//   with the inter-slice carry held in a register. Also yields the signed
//   less-than and signed overflow flags of the same subtraction. Results are
//   registered and held stable for the whole time out_valid is high, which the
//   downstream zero-detect stage relies on.
//
//   State table:
//     IDLE | waiting for operands, in_ready = 1
//     BUSY | one slice per cycle, NUM_SLICES cycles
//     DONE | result and flags valid, waiting for out_ready
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous active-low reset
//   in_valid       operands presented
//   in_ready       block can accept operands
//   data_operandA  minuend   (DATA_W)
//   data_operandB  subtrahend (DATA_W)
//   out_valid      result valid
//   out_ready      consumer accepts the result
//   sub_result     A - B modulo 2^DATA_W
//   isLessThan     signed A < B
//   overflow       signed overflow of A - B
//
// SLICE_W must divide DATA_W evenly (1, 2, 4, 8, 16 or 32 at DATA_W = 32).
// -----------------------------------------------------------------------------
module sliced_subtractor #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_operandA,
    input  logic [DATA_W-1:0] data_operandB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] sub_result,
    output logic              isLessThan,
    output logic              overflow
);

    localparam int NUM_SLICES = DATA_W / SLICE_W;
    localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int SUM_W      = SLICE_W + 1;
    localparam int MSB        = DATA_W - 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_acc;
    logic                r_carry;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_sub_result;
    logic                r_lt;
    logic                r_ovf;

    logic [31:0]         w_base;
    logic [SLICE_W-1:0]  w_slice_a;
    logic [SLICE_W-1:0]  w_slice_b;
    logic [SUM_W-1:0]    w_slice_sum;
    logic [DATA_W-1:0]   w_full;
    logic                w_ovf;
    logic                w_lt;

    assign w_base = 32'(r_cnt) * 32'(SLICE_W);

    // Subtraction as A + ~B + carry, with carry seeded to 1 on accept.
    always_comb begin
        w_slice_a   = r_a[w_base +: SLICE_W];
        w_slice_b   = r_b[w_base +: SLICE_W];
        w_slice_sum = {1'b0, w_slice_a} + {1'b0, ~w_slice_b} + SUM_W'(r_carry);
    end

    // Accumulator with the current slice merged in; on the last slice this is
    // the complete difference, so the flags come from it in the same cycle.
    always_comb begin
        w_full = r_acc;
        w_full[w_base +: SLICE_W] = w_slice_sum[SLICE_W-1:0];
    end

    assign w_ovf = (r_a[MSB] != r_b[MSB]) && (w_full[MSB] != r_a[MSB]);
    assign w_lt  = w_full[MSB] ^ w_ovf;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_carry      <= 1'b1;
            r_cnt        <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_sub_result <= '0;
            r_lt         <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= data_operandA;
                        r_b        <= data_operandB;
                        r_carry    <= 1'b1;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    r_acc   <= w_full;
                    r_carry <= w_slice_sum[SLICE_W];
                    if (r_cnt == LAST_SLICE) begin
                        r_cnt        <= '0;
                        r_sub_result <= w_full;
                        r_ovf        <= w_ovf;
                        r_lt         <= w_lt;
                        r_out_valid  <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign sub_result = r_sub_result;
    assign isLessThan = r_lt;
    assign overflow   = r_ovf;

endmodule
